// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and parameter helpers
// reused by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic bit stop_bits_legal(input int stop_bits);
    return (stop_bits == 1) || (stop_bits == 2);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the terminal count.
// A clear restarts the period so every new bit starts with a full count.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || (cnt_reg == CNT_LAST)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign o_tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and sends start, LSB-first
// data, optional parity and stop bits on a registered, glitch-free line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int SIZE_DATA  = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tx_en,
  input  logic                 i_fifo_empty,
  input  logic [SIZE_DATA-1:0] i_fifo_data,
  output logic                 o_fifo_rd_en,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int IDX_W = $clog2(SIZE_DATA + 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(SIZE_DATA - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic ODD_FLIP = (PARITY_ODD != 0);

  if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
  end

  tx_state_e            state_reg, state_next;
  logic [SIZE_DATA-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg, tx_next;
  logic                 done_reg, done_next;
  logic                 rd_en;
  logic                 baud_clr;
  logic                 tick;

  // Every state change restarts the bit period.
  assign baud_clr = (state_next != state_reg);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (baud_clr),
    .o_tick(tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      parity_reg  <= 1'b0;
      tx_reg      <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      parity_reg  <= parity_next;
      tx_reg      <= tx_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    parity_next  = parity_reg;
    done_next    = 1'b0;
    rd_en        = 1'b0;
    tx_next      = 1'b1;

    case (state_reg)
      IDLE: begin
        // Gated by reset so a held reset never drains the FIFO.
        if (i_tx_en && !i_fifo_empty && !i_rst) begin
          rd_en      = 1'b1;
          state_next = READ;
        end
      end
      READ: state_next = LATCH;
      LATCH: begin
        shift_next   = i_fifo_data;
        parity_next  = (^i_fifo_data) ^ ODD_FLIP;
        bit_idx_next = '0;
        state_next   = START;
      end
      START: begin
        if (tick) state_next = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == DATA_LAST) begin
            bit_idx_next = '0;
            state_next   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) state_next = STOP;
      end
      STOP: begin
        // bit_idx is reused to count stop bits.
        if (tick) begin
          if (bit_idx_reg == STOP_LAST) begin
            bit_idx_next = '0;
            done_next    = 1'b1;
            state_next   = IDLE;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
  end

  assign o_fifo_rd_en = rd_en;
  assign o_tx         = tx_reg;
  assign o_busy       = (state_reg != IDLE) || rd_en;
  assign o_done       = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations driven from one stimulus stream,
// each with a queue-based FIFO and a frame-timeline model checked every cycle.
module tb_uart_tx;

  localparam int N   = 3;
  localparam int CPB = 10;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic tx_en     = 1'b1;
  logic push_req  = 1'b0;
  logic [7:0] push_byte = 8'h00;

  logic [N-1:0] fempty = '1;
  logic [7:0]   fdata [N] = '{default: 8'h00};
  logic [N-1:0] rd_w, tx_w, busy_w, done_w;

  logic [7:0] fq  [N][$];
  logic [7:0] mq  [N][$];
  logic [7:0] dec [N][$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int off [N];
  int dcnt [N];
  int start_cyc [N];
  int prev_start [N];
  int last_rd [N];
  int last_done [N];
  int rdcnt [N];
  int mreads [N];
  logic [7:0]  cur_b [N];
  logic [11:0] dbits [N];
  logic [11:0] frame [N];

  function automatic int pe(input int i);
    return (i == 0) ? 0 : 1;
  endfunction
  function automatic int po(input int i);
    return (i == 2) ? 1 : 0;
  endfunction
  function automatic int sb(input int i);
    return (i == 1) ? 2 : 1;
  endfunction
  function automatic int nbits(input int i);
    return 1 + 8 + pe(i) + sb(i);
  endfunction
  function automatic int flen(input int i);
    return nbits(i) * CPB;
  endfunction
  function automatic int lit_len(input int i);
    case (i)
      0:       return 100;
      1:       return 120;
      default: return 110;
    endcase
  endfunction

  // Expected line level at offset o from the read cycle of byte b.
  function automatic logic line_level(input int i, input logic [7:0] b, input int o);
    int k;
    if (o < 3) return 1'b1;
    k = (o - 3) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (pe(i) != 0 && k == 9) return ((($countones(b) + po(i)) % 2) != 0);
    return 1'b1;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    uart_tx #(
      .SIZE_DATA (8),
      .CLK_FREQ  (1_000_000),
      .BAUD_RATE (100_000),
      .PARITY_EN (pe(gi)),
      .PARITY_ODD(po(gi)),
      .STOP_BITS (sb(gi))
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_tx_en     (tx_en),
      .i_fifo_empty(fempty[gi]),
      .i_fifo_data (fdata[gi]),
      .o_fifo_rd_en(rd_w[gi]),
      .o_tx        (tx_w[gi]),
      .o_busy      (busy_w[gi]),
      .o_done      (done_w[gi])
    );
  end

  always #5 clk = ~clk;

  // FIFO stand-in: registered read data one cycle after the read enable.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rd_w[i] && fq[i].size() > 0) fdata[i] <= fq[i].pop_front();
      if (push_req) fq[i].push_back(push_byte);
      fempty[i] <= (fq[i].size() == 0);
    end
  end

  task automatic chk(input string name, input int idx, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] cycle %0d: got %0h, expected %0h", name, idx, cyc, act, exp);
    end
  endtask

  task automatic monitor_cycle();
    int cur;
    logic exp_done;
    logic exp_tx;
    int k;
    cyc++;
    for (int i = 0; i < N; i++) begin
      cur = off[i];
      exp_done = 1'b0;
      if (cur == 3 + flen(i)) begin
        exp_done = 1'b1;
        cur = -1;
      end
      if (cur < 0 && tx_en && !fempty[i] && !rst) begin
        if (mq[i].size() > 0) cur_b[i] = mq[i].pop_front();
        mreads[i]++;
        cur = 0;
      end
      exp_tx = (cur >= 0) ? line_level(i, cur_b[i], cur) : 1'b1;
      chk("rd_busy_done_tx", i, {rd_w[i], busy_w[i], done_w[i], tx_w[i]},
          {(cur == 0), (cur >= 0), exp_done, exp_tx});
      off[i] = rst ? -1 : ((cur >= 0) ? cur + 1 : -1);
      if (push_req) mq[i].push_back(push_byte);

      // Line decoder: mid-bit sampling, independent of the model above.
      if (rd_w[i]) begin
        rdcnt[i]++;
        last_rd[i] = cyc;
      end
      if (done_w[i]) last_done[i] = cyc;
      if (rst) begin
        dcnt[i] = -1;
      end else if (dcnt[i] < 0) begin
        if (tx_w[i] == 1'b0) begin
          dcnt[i] = 0;
          prev_start[i] = start_cyc[i];
          start_cyc[i] = cyc;
          dbits[i] = '0;
        end
      end else begin
        dcnt[i]++;
        if (dcnt[i] % CPB == CPB / 2) begin
          k = dcnt[i] / CPB;
          dbits[i][k] = tx_w[i];
          if (k == nbits(i) - 1) begin
            dec[i].push_back(dbits[i][8:1]);
            frame[i] = dbits[i];
            dcnt[i] = -1;
          end
        end
      end
    end
  endtask

  function automatic bit idle_all();
    for (int i = 0; i < N; i++) begin
      if (off[i] >= 0 || dcnt[i] >= 0 || !fempty[i] || mq[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int last_dec(input int i);
    if (dec[i].size() == 0) return 'h100;
    return int'(dec[i][dec[i].size()-1]);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    push_req  = 1'b1;
    push_byte = b;
    step(1);
    push_req  = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (!idle_all() && n < lim) begin
      step(1);
      n++;
    end
    chk("idle_reached", 0, longint'(idle_all()), 1);
    step(2);
  endtask

  task automatic wait_dcnt(input int th, input int lim);
    int n;
    n = 0;
    while (dcnt[0] < th && n < lim) begin
      step(1);
      n++;
    end
    chk("frame_reached_bit", 0, longint'(dcnt[0] >= th), 1);
  endtask

  int rel_cyc;
  int en_cyc;
  int r0 [N];
  int dn [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      off[i] = -1;
      dcnt[i] = -1;
      start_cyc[i] = 0;
      prev_start[i] = 0;
      last_rd[i] = 0;
      last_done[i] = 0;
      rdcnt[i] = 0;
      mreads[i] = 0;
      cur_b[i] = 8'h00;
      dbits[i] = '0;
      frame[i] = '0;
    end
    fork
      forever begin
        @(negedge clk);
        monitor_cycle();
      end
    join_none

    // Reset held while the FIFO already holds 0xA5.
    step(1);
    push(8'hA5);
    step(1);
    chk("rd_count_in_reset", 0, rdcnt[0], 0);
    rst = 1'b0;
    rel_cyc = cyc + 1;
    wait_idle(400);
    chk("first_read_at_release", 0, last_rd[0] - rel_cyc, 0);
    chk("a5_frame_bits", 0, frame[0][9:0], 10'h34A);
    for (int i = 0; i < N; i++) begin
      chk("a5_byte", i, last_dec(i), 8'hA5);
      chk("rd_to_start", i, start_cyc[i] - last_rd[i], 3);
      chk("start_to_done", i, last_done[i] - start_cyc[i], lit_len(i));
      chk("a5_reads", i, rdcnt[i], 1);
    end

    // Back-to-back burst.
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_idle(800);
    chk("burst_gap", 0, start_cyc[0] - prev_start[0], 103);
    chk("burst_gap", 1, start_cyc[1] - prev_start[1], 123);
    for (int i = 0; i < N; i++) begin
      chk("burst_reads", i, rdcnt[i], 4);
      chk("burst_count", i, dec[i].size(), 4);
      chk("burst_b0", i, int'(dec[i][1]), 8'h00);
      chk("burst_b1", i, int'(dec[i][2]), 8'hFF);
      chk("burst_b2", i, int'(dec[i][3]), 8'h3C);
    end

    // Parity and two stop bits.
    push(8'h07);
    wait_idle(400);
    chk("parity_even_07", 1, frame[1][9], 1);
    chk("parity_odd_07", 2, frame[2][9], 0);
    chk("two_stop_bits", 1, frame[1][11:10], 2'b11);
    chk("two_stop_len", 1, last_done[1] - start_cyc[1], 120);
    chk("byte_07", 0, last_dec(0), 8'h07);

    // Enable dropped mid-frame with two bytes queued.
    for (int i = 0; i < N; i++) r0[i] = rdcnt[i];
    push(8'h81);
    push(8'h42);
    wait_dcnt(35, 300);
    tx_en = 1'b0;
    step(200);
    for (int i = 0; i < N; i++) begin
      chk("en_low_one_read", i, rdcnt[i] - r0[i], 1);
      chk("en_low_byte", i, last_dec(i), 8'h81);
      chk("en_low_fifo_kept", i, fempty[i], 0);
    end
    tx_en = 1'b1;
    en_cyc = cyc + 1;
    wait_idle(400);
    for (int i = 0; i < N; i++) begin
      chk("reenable_read_cycle", i, last_rd[i] - en_cyc, 0);
      chk("reenable_byte", i, last_dec(i), 8'h42);
    end

    // Reset in the middle of data bit 4 of 0x5A.
    for (int i = 0; i < N; i++) dn[i] = dec[i].size();
    push(8'h5A);
    wait_dcnt(55, 300);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    for (int i = 0; i < N; i++) begin
      chk("rst_tx_high", i, tx_w[i], 1);
      chk("rst_not_busy", i, busy_w[i], 0);
      chk("rst_discard", i, dec[i].size(), dn[i]);
    end
    push(8'h11);
    wait_idle(400);
    for (int i = 0; i < N; i++) begin
      chk("after_rst_byte", i, last_dec(i), 8'h11);
      chk("after_rst_count", i, dec[i].size(), dn[i] + 1);
    end

    // Randomized traffic, enable toggling and rare resets.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 12) begin
        push(8'($urandom));
      end else if (r < 30) begin
        tx_en = ~tx_en;
        step(1);
      end else if (r == 999) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end else begin
        step(1);
      end
    end
    tx_en = 1'b1;
    wait_idle(8000);
    for (int i = 0; i < N; i++) chk("total_reads", i, rdcnt[i], mreads[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART IP, sitting directly downstream of the TX `fifo`. It pops one byte at a time from the FIFO whenever the FIFO is non-empty and transmission is enabled. Each byte goes out on the line as a standard asynchronous frame: start bit, LSB-first data, optional parity, then stop bit(s). It owns the FIFO read handshake and the baud-rate timing.

## Interface
- `SIZE_DATA`, 8: data bits per frame; equals the FIFO `SIZE_DATA`.
- `CLK_FREQ`, 50_000_000: `i_clk` frequency in Hz.
- `BAUD_RATE`, 115200: line rate. `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE`, integer divide, must be ≥ 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN = 0`.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `i_clk`, in, 1: the single clock.
- `i_rst`, in, 1: reset, synchronous and active-high.
- `i_tx_en`, in, 1: enables the start of new frames. A frame already in progress always completes.
- `i_fifo_empty`, in, 1: FIFO `o_fifo_empty`.
- `i_fifo_data`, in, `SIZE_DATA`: FIFO `o_data`.
- `o_fifo_rd_en`, out, 1: FIFO `i_en_rd`; a single-cycle pulse per byte.
- `o_tx`, out, 1: serial line, idles high.
- `o_busy`, out, 1: high from the read pulse through the end of the last stop bit.
- `o_done`, out, 1: single-cycle pulse in the cycle after the last stop bit ends.

## Operation
- Reset values: `o_tx=1`, `o_busy=0`, `o_fifo_rd_en=0`, `o_done=0`, FSM in IDLE, baud counter 0, bit index 0, shift register 0.
- FSM states: IDLE → READ → LATCH → START → DATA → [PARITY] → STOP → IDLE.
- IDLE: when `i_tx_en=1` and `i_fifo_empty=0`, assert `o_fifo_rd_en` for that cycle and go to READ.
- READ: the FIFO presents the word one cycle after the read enable. Go to LATCH.
- LATCH: capture `i_fifo_data` into the shift register. Compute parity as XOR of the data bits, inverted when `PARITY_ODD=1`. Go to START.
- START: drive `o_tx=0` for `CLKS_PER_BIT` cycles.
- DATA: drive `shift[0]` for `CLKS_PER_BIT` cycles, shift right, increment the bit index. After `SIZE_DATA` bits, go to PARITY if `PARITY_EN=1`, otherwise to STOP.
- PARITY: drive the parity bit for `CLKS_PER_BIT` cycles.
- STOP: drive `o_tx=1` for `STOP_BITS*CLKS_PER_BIT` cycles, then pulse `o_done` and go to IDLE.
- The baud counter counts 0..`CLKS_PER_BIT-1` and clears on every state entry. Its width is `$clog2(CLKS_PER_BIT)`. Bit boundaries occur on terminal count only.
- `i_tx_en` deasserted mid-frame: the frame finishes, and no new read is issued until `i_tx_en` is high again.
- FIFO empty: no read is issued, and `o_tx` stays high indefinitely.
- `o_fifo_rd_en` is never asserted while `i_fifo_empty=1` or outside IDLE. Each read pulse produces exactly one frame.
- `i_rst` mid-frame: all outputs take their reset values at the next edge and the in-flight byte is discarded. The FIFO itself is reset by its own reset.

## Timing
- Read to line: `o_fifo_rd_en` in cycle N, `o_tx` falls for the start bit at cycle N+3 (transitions IDLE→READ, READ→LATCH, LATCH→START).
- Frame length is `(1 + SIZE_DATA + PARITY_EN + STOP_BITS) * CLKS_PER_BIT` cycles, measured from the first start-bit cycle.
- Back-to-back frames: `o_done` is asserted in the IDLE cycle, and a new `o_fifo_rd_en` may occur in that same cycle. This gives exactly 3 extra high cycles between the last stop-bit cycle and the next start bit.
- `o_tx` is registered, so there are no glitches on the line.

## Structure
- Shared package `uart_pkg`:
  - `tx_state_e` enum (IDLE, READ, LATCH, START, DATA, PARITY, STOP);
  - function `clks_per_bit(CLK_FREQ, BAUD_RATE)`;
  - `STOP_BITS` legality check, shared with the future `uart_rx`.
- Sub-module `uart_baud_cnt`: parameterised `CLKS_PER_BIT`, inputs `i_clk`, `i_rst`, `i_clr`, output `o_tick` (terminal count). It is reused by the receiver.
- Everything else (FSM, shift register, parity) lives in `uart_tx`.

## Test plan
All scenarios use `CLK_FREQ=1_000_000`, `BAUD_RATE=100_000` (10 cycles per bit), and a real `fifo` instance with `SIZE_DEPTH=16`.

1. Reset: hold `i_rst` for 3 cycles with the FIFO holding data → `o_tx=1`, `o_busy=0`, `o_fifo_rd_en=0` throughout. First read occurs exactly 1 cycle after release.
2. Single byte 0xA5, no parity, 1 stop → line reads 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles. `o_done` pulses once, 100 cycles after the start bit begins. FIFO ends empty.
3. Burst 0x00, 0xFF, 0x3C written back-to-back → three frames with exactly 3 high cycles between the end of each stop bit and the next start. Exactly 3 read pulses, and the bytes are decoded in order.
4. `PARITY_EN=1`: byte 0x07 → parity bit 1 with `PARITY_ODD=0`, 0 with `PARITY_ODD=1`. `STOP_BITS=2` makes the stop phase 20 cycles.
5. `i_tx_en` deasserted during the data bits of byte 1 with 2 bytes queued → byte 1 completes and byte 2 is not read. Reasserting `i_tx_en` starts the read 1 cycle later.
6. `i_rst` pulsed at bit 4 of 0x5A → `o_tx=1` at the next edge and `o_busy=0`. With the FIFO refilled with 0x11 after reset, the next frame carries 0x11 cleanly.
